// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU: single-cycle base ops plus iterative M-extension
// multiply (radix-2 shift-add) and divide (restoring), behind valid/ready.
module alu_mc #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      ALUCode,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ALUResult,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW:0] CNT_INIT = (SHW+1)'(XLEN);
  localparam logic [SHW:0] CNT_LAST = (SHW+1)'(1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state, next_state;
  logic [SHW:0]    counter;
  logic [XLEN-1:0] acc_hi, acc_lo, op_b;
  logic            neg_res, sel_hi;

  logic [SHW-1:0]  shamt;
  logic            is_mul, is_div, accept;
  logic [XLEN-1:0] base_result;
  logic            sign_a, sign_b, neg_init, sel_init;
  logic [XLEN-1:0] mag_a, mag_b;

  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_n, mul_lo_n, mul_final;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN:0]     div_shift, div_diff;
  logic [XLEN-1:0]   rem_n, quo_n, div_pick, div_final;

  assign shamt  = B[SHW-1:0];
  assign is_mul = (ALUCode[4:2] == 3'b100);
  assign is_div = (ALUCode[4:2] == 3'b101);
  assign accept = (state == IDLE) && in_valid && !flush;

  // Single-cycle base operations; undefined codes fall back to add
  always_comb begin
    base_result = A + B;
    case (ALUCode)
      5'h01:   base_result = A - B;
      5'h02:   base_result = B;
      5'h03:   base_result = A & B;
      5'h04:   base_result = A ^ B;
      5'h05:   base_result = A | B;
      5'h06:   base_result = A << shamt;
      5'h07:   base_result = A >> shamt;
      5'h08:   base_result = $unsigned($signed(A) >>> shamt);
      5'h09:   base_result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
      5'h0A:   base_result = {{(XLEN-1){1'b0}}, (A < B)};
      default: base_result = A + B;
    endcase
  end

  // Operand sign capture: iterate on magnitudes, fix the sign at the end
  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (ALUCode)
      5'h11, 5'h14, 5'h16: begin
        sign_a = A[XLEN-1];
        sign_b = B[XLEN-1];
      end
      5'h12:   sign_a = A[XLEN-1];
      default: ;
    endcase
    mag_a = sign_a ? -A : A;
    mag_b = sign_b ? -B : B;
    // A zero divisor yields an all-ones quotient magnitude that must stay unsigned
    if (is_mul)
      neg_init = sign_a ^ sign_b;
    else if (ALUCode[1])
      neg_init = sign_a;
    else
      neg_init = (sign_a ^ sign_b) && (B != '0);
    sel_init = is_mul ? (ALUCode[1:0] != 2'b00) : ALUCode[1];
  end

  // One shift-add multiply step and one restoring divide step, plus final sign fix
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : '0);
    mul_hi_n  = mul_sum[XLEN:1];
    mul_lo_n  = {mul_sum[0], acc_lo[XLEN-1:1]};
    prod_s    = neg_res ? -{mul_hi_n, mul_lo_n} : {mul_hi_n, mul_lo_n};
    mul_final = sel_hi ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];

    div_shift = {acc_hi, acc_lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, op_b};
    if (div_diff[XLEN]) begin
      rem_n = div_shift[XLEN-1:0];
      quo_n = {acc_lo[XLEN-2:0], 1'b0};
    end else begin
      rem_n = div_diff[XLEN-1:0];
      quo_n = {acc_lo[XLEN-2:0], 1'b1};
    end
    div_pick  = sel_hi ? rem_n : quo_n;
    div_final = neg_res ? -div_pick : div_pick;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Next-state and handshake outputs; flush overrides every transition
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          next_state = is_mul ? MUL : (is_div ? DIV : DONE);
      end
      MUL: begin
        busy = 1'b1;
        if (counter == CNT_LAST) next_state = DONE;
      end
      DIV: begin
        busy = 1'b1;
        if (counter == CNT_LAST) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  // Datapath: latch operands on accept, iterate, and register the final result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter   <= '0;
      ALUResult <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      op_b      <= '0;
      neg_res   <= 1'b0;
      sel_hi    <= 1'b0;
    end else if (flush) begin
      counter <= '0;
    end else if (accept) begin
      if (is_mul) begin
        acc_hi  <= '0;
        acc_lo  <= mag_b;
        op_b    <= mag_a;
        counter <= CNT_INIT;
        neg_res <= neg_init;
        sel_hi  <= sel_init;
      end else if (is_div) begin
        acc_hi  <= '0;
        acc_lo  <= mag_a;
        op_b    <= mag_b;
        counter <= CNT_INIT;
        neg_res <= neg_init;
        sel_hi  <= sel_init;
      end else begin
        ALUResult <= base_result;
      end
    end else if (state == MUL) begin
      acc_hi  <= mul_hi_n;
      acc_lo  <= mul_lo_n;
      counter <= counter - CNT_LAST;
      if (counter == CNT_LAST) ALUResult <= mul_final;
    end else if (state == DIV) begin
      acc_hi  <= rem_n;
      acc_lo  <= quo_n;
      counter <= counter - CNT_LAST;
      if (counter == CNT_LAST) ALUResult <= div_final;
    end
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle, parametrised successor of the single-cycle datapath ALU.
- Keeps the 11 base RV32I operations and their code values. Adds the RV M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) through an iterative radix-2 shift-add multiplier and a restoring divider.
- Sits in the EX stage behind a valid/ready handshake. The pipeline stalls on in_ready/out_valid instead of assuming 1-cycle results.

Parameters:
- XLEN, 32, operand/result width; power of two, >= 8.
- SHW, log2(XLEN) (derived localparam, not overridable), number of shift-amount bits taken from B.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort of any in-flight or held operation.
- in_valid  input  1  operands and code are valid.
- in_ready  output  1  block can accept an operation this cycle.
- ALUCode  input  5  operation select.
- A  input  XLEN  operand A / rs1 / dividend / multiplicand.
- B  input  XLEN  operand B / rs2 / divisor / multiplier.
- out_valid  output  1  ALUResult holds a completed result.
- out_ready  input  1  consumer takes the result this cycle.
- ALUResult  output  XLEN  result, registered.
- busy  output  1  high in MUL or DIV state.

Behaviour:
- Clock/reset: one clock `clk`; reset `reset` is asynchronous and active-high.
- While `reset` is high, all state clears immediately, regardless of the clock:
  - state = IDLE, counter = 0, ALUResult = 0;
  - out_valid = 0, busy = 0;
  - in_ready = 1 once state is IDLE.
- Codes:
  - 0x00 add, 0x01 sub, 0x02 lui (pass B), 0x03 and, 0x04 xor, 0x05 or, 0x06 sll, 0x07 srl, 0x08 sra, 0x09 slt, 0x0A sltu.
  - 0x10 mul, 0x11 mulh, 0x12 mulhsu, 0x13 mulhu, 0x14 div, 0x15 divu, 0x16 rem, 0x17 remu.
  - Any other code behaves as add.
- Shifts: use B[SHW-1:0] only; upper bits of B are ignored. sra replicates A[XLEN-1].
- slt/sltu: result is 1 or 0, zero-extended to XLEN.
- States:
  - IDLE: in_ready = 1.
  - MUL: busy = 1, in_ready = 0.
  - DIV: busy = 1, in_ready = 0.
  - DONE: out_valid = 1, in_ready = 0.
- Accept: in_valid && in_ready at a rising edge.
  - Base code: ALUResult is computed and registered at that edge, state -> DONE. out_valid is high the next cycle, i.e. latency 1.
  - Mul/div code: operands are latched (signs and magnitudes captured per op), counter = XLEN, state -> MUL or DIV.
- MUL/DIV iteration:
  - One radix-2 step per cycle; counter decrements each cycle.
  - On the step where counter == 1, the final result (sign-corrected) is written to ALUResult and state -> DONE.
  - out_valid therefore rises XLEN cycles after the accept edge.
  - Latency is fixed and data-independent, including the special cases below.
- Multiply results:
  - Full 2*XLEN product.
  - mul returns the low half.
  - mulh/mulhsu/mulhu return the high half; signedness is s*s, s*u, u*u respectively.
- Divide results:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero: div/divu give all-ones; rem/remu give A.
  - Signed overflow (A = most-negative, B = -1): div gives A; rem gives 0.
- DONE: ALUResult and out_valid are held stable until out_ready is high at an edge, then state -> IDLE. There is no same-cycle re-accept, so base-op throughput is one op per 2 cycles.
- flush:
  - Sampled at each edge; overrides every other transition.
  - Next state is IDLE, out_valid = 0, any in-flight result is discarded.
  - ALUResult holds its last value.
  - flush together with in_valid in IDLE: the op is NOT accepted.
- Async reset mid-MUL/DIV or in DONE: the result is lost and outputs clear immediately. The first op after reset deasserts can be accepted at the next edge.
- in_valid is ignored while in_ready = 0. Operands need not be held after accept.

Test Plan:
- ADD A=7, B=5 accepted at edge 0 -> out_valid=1 after edge 1, ALUResult=12. Held with out_ready=0 for 5 cycles (in_ready=0 throughout). out_ready=1 -> IDLE, in_ready=1 next cycle.
- SRA A=0x80000000, B=0x00000024 -> 0xF8000000 (shift 4). SLL A=1, B=0x21 -> 0x00000002. SLTU A=1, B=0xFFFFFFFF -> 1; SLT same operands -> 0.
- MULH A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF. MULHU same -> 0x00000001. MUL same -> 0xFFFFFFFE. MULHSU same -> 0xFFFFFFFF. Each: busy=1 for 32 cycles, out_valid exactly 32 cycles after accept.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD. REM same -> 0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM -> 0. DIVU A=100, B=0 -> 0xFFFFFFFF; REMU -> 100. All with 32-cycle latency.
- flush asserted 10 cycles into a DIVU -> IDLE next cycle, out_valid never rises. A following ADD 1+1 returns 2 with latency 1.
- Async reset raised between clock edges 15 cycles into a MUL -> out_valid=0, busy=0, ALUResult=0 immediately, before the next edge. After release, MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
